// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: command codes, FSM states and status-byte helper for the SPI target front end.
package spi_slave_pkg;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h0B;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_QWRITE = 8'h32;
  localparam logic [7:0] CMD_QREAD  = 8'h6B;
  typedef enum logic [3:0] {IDLE, CMD, WR_ADDR, RD_ADDR, DUMMY, WR_DATA, RD_DATA, STATUS, IGNORE} state_e;
  function automatic logic [7:0] status_byte(input logic ovf, input logic udf, input logic rxv, input logic txv);
    return {4'b0, ovf, udf, rxv, txv};
  endfunction
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: synchronizes SPI pins into clk and derives sclk/csn edge strobes.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       csn_i,
  input  logic [3:0] sdi_i,
  output logic       rise_o,
  output logic       fall_o,
  output logic       csn_fall_o,
  output logic       csn_rise_o,
  output logic       csn_o,
  output logic [3:0] sdi_o
);
  // bit layout {sclk, csn, sdi[3:0]}; csn resets high so leaving reset is not a deselect edge
  localparam logic [5:0] RST_VAL = 6'b010000;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [1:0] prev_q;
  logic [5:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_VAL;
      prev_q <= 2'b01;
    end else begin
      sync_q[0] <= {sclk_i, csn_i, sdi_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1][5:4];
    end
  assign s          = sync_q[SYNC_STAGES-1];
  assign rise_o     = s[5] & ~prev_q[1];
  assign fall_o     = ~s[5] & prev_q[1];
  assign csn_fall_o = ~s[4] & prev_q[0];
  assign csn_rise_o = s[4] & ~prev_q[0];
  assign csn_o      = s[4];
  assign sdi_o      = s[3:0];
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: oversampled SPI mode-0 target decoding cmd/addr/dummy and streaming 32-bit words.
// Quad commands 0x32/0x6B are decoded only when SPI_SLAVE_QUAD_EN is defined.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int ADDR_LEN     = 32,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        spi_sclk,
  input  logic        spi_csn,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [3:0]  spi_oe,
  output logic [31:0] addr_o,
  output logic        addr_valid_o,
  output logic [7:0]  cmd_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        eot_o,
  output logic [1:0]  status_o
);
  localparam logic [5:0]  ALEN      = 6'(ADDR_LEN);
  localparam logic [5:0]  DLEN      = 6'(DUMMY_CYCLES);
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - ADDR_LEN);
  logic rise_evt, fall_evt, csn_fall, csn_rise, csn_s;
  logic [3:0] sdi_s;
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d, cnt_nx, step;
  logic [31:0] shift_q, shift_d, addr_q, addr_d, rx_data_q, rx_data_d, tx_shift_q, tx_shift_d;
  logic [7:0] cmd_q, cmd_d;
  logic [3:0] sdo_q, sdo_d;
  logic rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d, addr_valid_q, addr_valid_d, eot_q, eot_d;
  logic ovf_q, ovf_d, udf_q, udf_d, quad_q, quad_d;
  logic fetch, ovf_set, udf_set, flag_clr;
  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .sclk_i     (spi_sclk),
    .csn_i      (spi_csn),
    .sdi_i      ({spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0}),
    .rise_o     (rise_evt),
    .fall_o     (fall_evt),
    .csn_fall_o (csn_fall),
    .csn_rise_o (csn_rise),
    .csn_o      (csn_s),
    .sdi_o      (sdi_s)
  );
  assign step   = quad_q ? 6'd4 : 6'd1;
  assign cnt_nx = cnt_q + step;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    quad_d       = quad_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready_i;
    tx_shift_d   = tx_shift_q;
    sdo_d        = sdo_q;
    addr_valid_d = 1'b0;
    tx_ready_d   = 1'b0;
    eot_d        = 1'b0;
    fetch        = 1'b0;
    ovf_set      = 1'b0;
    udf_set      = 1'b0;
    flag_clr     = 1'b0;
    if (csn_rise) begin
      state_d  = IDLE;
      cnt_d    = '0;
      eot_d    = 1'b1;
      sdo_d    = '0;
      quad_d   = 1'b0;
      flag_clr = state_q == STATUS;
    end else if (csn_fall && state_q == IDLE) begin
      state_d = CMD;
      cnt_d   = '0;
    end else if (rise_evt) begin
      shift_d = quad_q ? {shift_q[27:0], sdi_s} : {shift_q[30:0], sdi_s[0]};
      cnt_d   = cnt_nx;
      case (state_q)
        CMD: if (cnt_q == 6'd7) begin
          cnt_d = '0;
          case (shift_d[7:0])
            CMD_WRITE:  state_d = WR_ADDR;
            CMD_READ:   state_d = RD_ADDR;
            CMD_STATUS: begin
              state_d    = STATUS;
              tx_shift_d = {status_byte(ovf_q, udf_q, rx_valid_q, tx_valid_i), 24'h0};
            end
`ifdef SPI_SLAVE_QUAD_EN
            CMD_QWRITE: begin state_d = WR_ADDR; quad_d = 1'b1; end
            CMD_QREAD:  begin state_d = RD_ADDR; quad_d = 1'b1; end
`endif
            default:    state_d = IGNORE;
          endcase
          cmd_d = (state_d == IGNORE) ? cmd_q : shift_d[7:0];
        end
        WR_ADDR, RD_ADDR: if (cnt_nx >= ALEN) begin
          cnt_d        = '0;
          addr_d       = shift_d & ADDR_MASK;
          addr_valid_d = 1'b1;
          state_d      = (state_q == WR_ADDR) ? WR_DATA : (DUMMY_CYCLES == 0) ? RD_DATA : DUMMY;
          fetch        = state_q == RD_ADDR && DUMMY_CYCLES == 0;
        end
        DUMMY: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q + 6'd1 >= DLEN) begin
            cnt_d   = '0;
            state_d = RD_DATA;
            fetch   = 1'b1;
          end
        end
        WR_DATA: if (cnt_nx >= 6'd32) begin
          cnt_d = '0;
          // a word still waiting on the sink is kept; the newcomer is dropped
          if (rx_valid_q && !rx_ready_i) ovf_set = 1'b1;
          else begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
          end
        end
        RD_DATA: if (cnt_nx >= 6'd32) begin
          cnt_d = '0;
          fetch = 1'b1;
        end
        STATUS: if (cnt_q == 6'd7) begin
          cnt_d      = '0;
          tx_shift_d = {status_byte(ovf_q, udf_q, rx_valid_q, tx_valid_i), 24'h0};
        end
        default: ;
      endcase
    end else if (fall_evt && (state_q == RD_DATA || state_q == STATUS)) begin
      sdo_d      = quad_q ? tx_shift_q[31:28] : {3'b0, tx_shift_q[31]};
      tx_shift_d = quad_q ? tx_shift_q << 4 : tx_shift_q << 1;
    end
    if (fetch) begin
      tx_shift_d = tx_valid_i ? tx_data_i : 32'h0;
      tx_ready_d = tx_valid_i;
      udf_set    = ~tx_valid_i;
    end
    ovf_d = ovf_set | (ovf_q & ~flag_clr);
    udf_d = udf_set | (udf_q & ~flag_clr);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      quad_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_shift_q   <= '0;
      sdo_q        <= '0;
      addr_valid_q <= 1'b0;
      tx_ready_q   <= 1'b0;
      eot_q        <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      quad_q       <= quad_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_shift_q   <= tx_shift_d;
      sdo_q        <= sdo_d;
      addr_valid_q <= addr_valid_d;
      tx_ready_q   <= tx_ready_d;
      eot_q        <= eot_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  assign spi_oe[0]    = (state_q == RD_DATA || state_q == STATUS) & ~csn_s;
  assign spi_oe[3:1]  = {3{state_q == RD_DATA & quad_q & ~csn_s}};
  assign spi_sdo0     = sdo_q[0] & spi_oe[0];
  assign spi_sdo1     = sdo_q[1] & spi_oe[1];
  assign spi_sdo2     = sdo_q[2] & spi_oe[2];
  assign spi_sdo3     = sdo_q[3] & spi_oe[3];
  assign addr_o       = addr_q;
  assign addr_valid_o = addr_valid_q;
  assign cmd_o        = cmd_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_ready_o   = tx_ready_q;
  assign eot_o        = eot_q;
  assign status_o     = {udf_q, ovf_q};
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: SPI master model driving spi_slave_ctrl from a vector table plus corner sequences.
// Quad write sequence is included when SPI_SLAVE_QUAD_EN is defined.
module tb_spi_slave_ctrl;
  localparam int H = 6;
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    int          nw;
    logic [1:0]  st;
    logic [7:0]  cmd_exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, csn = 1'b1;
  logic [3:0] sdi = '0, miso;
  logic spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3, addr_valid_o, rx_valid_o, tx_ready_o, eot_o;
  logic [3:0] spi_oe;
  logic [31:0] addr_o, rx_data_o, tx_data = '0, w;
  logic [7:0] cmd_o;
  logic [1:0] status_o;
  logic rx_ready = 1'b1, tx_valid = 1'b0, oe_ok = 1'b0;
  logic [31:0] rx_exp_q[$], addr_exp_q[$], rd_exp_q[$], src_q[$];
  int checks = 0, errors = 0, eots = 0, pops = 0, oe_bad = 0, e0, p0;
  vec_t tbl[5];
  spi_slave_ctrl dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .spi_sclk      (sclk),
    .spi_csn       (csn),
    .spi_sdi0      (sdi[0]),
    .spi_sdi1      (sdi[1]),
    .spi_sdi2      (sdi[2]),
    .spi_sdi3      (sdi[3]),
    .spi_sdo0      (spi_sdo0),
    .spi_sdo1      (spi_sdo1),
    .spi_sdo2      (spi_sdo2),
    .spi_sdo3      (spi_sdo3),
    .spi_oe        (spi_oe),
    .addr_o        (addr_o),
    .addr_valid_o  (addr_valid_o),
    .cmd_o         (cmd_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .eot_o         (eot_o),
    .status_o      (status_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // TX source FIFO and output monitors, evaluated away from the active edge
  always @(negedge clk) begin
    if (tx_ready_o) begin
      pops++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    tx_valid = src_q.size() != 0;
    tx_data  = tx_valid ? src_q[0] : 32'h0;
    if (eot_o) eots++;
    if (!oe_ok && spi_oe !== 4'h0) oe_bad++;
    if (addr_valid_o) begin
      if (addr_exp_q.size() == 0) chk("addr_unexpected", {31'b0, addr_valid_o}, 32'h0);
      else chk("addr", addr_o, addr_exp_q.pop_front());
    end
    if (rx_valid_o && rx_ready) begin
      if (rx_exp_q.size() == 0) chk("rx_unexpected", rx_data_o, 32'hx);
      else chk("rx_word", rx_data_o, rx_exp_q.pop_front());
    end
  end
  task automatic wait_h();
    repeat (H) @(posedge clk);
    #1;
  endtask
  task automatic bit_x(input logic [3:0] o);
    sdi = o;
    wait_h();
    miso = {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0};
    sclk = 1'b1;
    wait_h();
    sclk = 1'b0;
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int b = n - 1; b >= 0; b--) bit_x({3'b0, v[b]});
  endtask
  task automatic recv(input int n, output logic [31:0] v);
    v = '0;
    for (int b = 0; b < n; b++) begin
      bit_x(4'h0);
      v = {v[30:0], miso[0]};
    end
  endtask
`ifdef SPI_SLAVE_QUAD_EN
  task automatic send_q(input logic [31:0] v, input int nib);
    logic [31:0] t;
    for (int k = nib - 1; k >= 0; k--) begin
      t = v >> (4 * k);
      bit_x(t[3:0]);
    end
  endtask
`endif
  task automatic start();
    csn = 1'b0;
    wait_h();
  endtask
  task automatic stop();
    wait_h();
    csn = 1'b1;
    repeat (3) wait_h();
  endtask
  task automatic status_rd(input logic [7:0] exp);
    oe_ok = 1'b1;
    start();
    send(32'h05, 8);
    recv(8, w);
    chk("status_byte0", w, {24'h0, exp});
    recv(8, w);
    chk("status_byte1", w, {24'h0, exp});
    stop();
    oe_ok = 1'b0;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached with checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{8'h02, 32'h1000_0004, 32'hA5A5_1234, 1, 2'b00, 8'h02};
    tbl[1] = '{8'h02, 32'hFFFF_FFFF, 32'h0000_0001, 1, 2'b00, 8'h02};
    tbl[2] = '{8'h0B, 32'h0000_0000, 32'hCAFE_F00D, 2, 2'b10, 8'h0B};
    tbl[3] = '{8'h0B, 32'h0000_0080, 32'h8000_0001, 1, 2'b10, 8'h0B};
    tbl[4] = '{8'h9F, 32'h0000_0000, 32'h0000_0000, 0, 2'b10, 8'h0B};
    repeat (4) @(posedge clk);
    #1;
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_rx", rx_data_o, 32'h0);
    chk("rst_misc", 32'({cmd_o, spi_oe, status_o, addr_valid_o, rx_valid_o, tx_ready_o, eot_o,
                         spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0}), 32'h0);
    rst_n = 1'b1;
    repeat (4) wait_h();
    chk("rst_eot", eots, 0);
    for (int i = 0; i < 5; i++) begin
      e0    = eots;
      p0    = pops;
      oe_ok = tbl[i].cmd == 8'h0B;
      if (tbl[i].cmd == 8'h0B) begin
        src_q.push_back(tbl[i].data);
        rd_exp_q.push_back(tbl[i].data);
        for (int k = 1; k < tbl[i].nw; k++) rd_exp_q.push_back(32'h0);
      end
      start();
      send({24'h0, tbl[i].cmd}, 8);
      if (tbl[i].cmd == 8'h02) begin
        addr_exp_q.push_back(tbl[i].addr);
        send(tbl[i].addr, 32);
        rx_exp_q.push_back(tbl[i].data);
        send(tbl[i].data, 32);
      end else if (tbl[i].cmd == 8'h0B) begin
        addr_exp_q.push_back(tbl[i].addr);
        send(tbl[i].addr, 32);
        send(32'h0, 8);
        for (int k = 0; k < tbl[i].nw; k++) begin
          recv(32, w);
          chk("rd_word", w, rd_exp_q.pop_front());
        end
      end else send(32'h1234_5678, 32);
      stop();
      oe_ok = 1'b0;
      chk("eot_pulse", eots - e0, 1);
      chk("status", {30'h0, status_o}, {30'h0, tbl[i].st});
      chk("cmd", {24'h0, cmd_o}, {24'h0, tbl[i].cmd_exp});
      chk("tx_pops", pops - p0, (tbl[i].cmd == 8'h0B) ? 1 : 0);
      chk("rx_drain", rx_exp_q.size(), 0);
      chk("rx_valid_idle", {31'h0, rx_valid_o}, 32'h0);
      chk("oe_off", oe_bad, 0);
    end
    status_rd(8'h04);
    chk("status_clr", {30'h0, status_o}, 32'h0);
    chk("status_cmd", {24'h0, cmd_o}, 32'h05);
    rx_ready = 1'b0;
    start();
    send(32'h02, 8);
    addr_exp_q.push_back(32'h0000_0040);
    send(32'h0000_0040, 32);
    rx_exp_q.push_back(32'h1111_2222);
    send(32'h1111_2222, 32);
    send(32'h3333_4444, 32);
    stop();
    chk("ovf_status", {30'h0, status_o}, 32'h1);
    chk("ovf_held_valid", {31'h0, rx_valid_o}, 32'h1);
    chk("ovf_held_data", rx_data_o, 32'h1111_2222);
    status_rd(8'h0A);
    chk("ovf_clr", {30'h0, status_o}, 32'h0);
    chk("ovf_retained", {31'h0, rx_valid_o}, 32'h1);
    rx_ready = 1'b1;
    wait_h();
    chk("ovf_drain", rx_exp_q.size(), 0);
    e0 = eots;
    start();
    send(32'h02, 8);
    addr_exp_q.push_back(32'h0000_0100);
    send(32'h0000_0100, 32);
    send(32'h1BAD, 13);
    stop();
    chk("abort_rx_valid", {31'h0, rx_valid_o}, 32'h0);
    chk("abort_eot", eots - e0, 1);
    start();
    send(32'h02, 8);
    addr_exp_q.push_back(32'h0000_00AA);
    send(32'h0000_00AA, 32);
    rx_exp_q.push_back(32'h5555_AAAA);
    send(32'h5555_AAAA, 32);
    stop();
    chk("abort_next_rx", rx_exp_q.size(), 0);
    src_q.push_back(32'hDEAD_BEEF);
    oe_ok = 1'b1;
    start();
    send(32'h0B, 8);
    addr_exp_q.push_back(32'h0000_0200);
    send(32'h0000_0200, 32);
    send(32'h0, 8);
    recv(10, w);
    chk("mid_read_bits", w, 32'h0000_037A);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_addr", addr_o, 32'h0);
    chk("rst_mid_misc", 32'({cmd_o, spi_oe, status_o, addr_valid_o, rx_valid_o, tx_ready_o, eot_o,
                             spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0}), 32'h0);
    csn  = 1'b1;
    sclk = 1'b0;
    repeat (3) wait_h();
    rst_n = 1'b1;
    oe_ok = 1'b0;
    wait_h();
    e0 = eots;
    start();
    send(32'h02, 8);
    addr_exp_q.push_back(32'h2000_0000);
    send(32'h2000_0000, 32);
    rx_exp_q.push_back(32'h0F0F_F0F0);
    send(32'h0F0F_F0F0, 32);
    stop();
    chk("post_rst_rx", rx_exp_q.size(), 0);
    chk("post_rst_eot", eots - e0, 1);
    chk("post_rst_cmd", {24'h0, cmd_o}, 32'h02);
`ifdef SPI_SLAVE_QUAD_EN
    start();
    send(32'h32, 8);
    addr_exp_q.push_back(32'h0000_0300);
    send_q(32'h0000_0300, 8);
    rx_exp_q.push_back(32'h1234_5678);
    send_q(32'h1234_5678, 8);
    stop();
    chk("quad_rx", rx_exp_q.size(), 0);
    chk("quad_cmd", {24'h0, cmd_o}, 32'h32);
`endif
    chk("queues_empty", addr_exp_q.size() + rd_exp_q.size(), 0);
    chk("oe_final", oe_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
